// File: rtl/axi_pkg.sv
// Shared AXI encodings for the burst read slave and its address generator.
// Also holds the read-slave state type.
package axi_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_t;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  // WRAP bursts are only legal with 2, 4, 8 or 16 beats.
  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational AXI next-beat address generator (FIXED/INCR/WRAP).
// Shared between the read slave and the future write slave.
module axi_burst_addr_gen
  import axi_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        len,
  input  logic [2:0]        size,
  input  logic [1:0]        burst,
  output logic [ADDR_W-1:0] next_addr
);

  logic [ADDR_W-1:0] beat_bytes;
  logic [ADDR_W-1:0] aligned;
  logic [ADDR_W-1:0] incr;
  logic [ADDR_W-1:0] wrap_size;
  logic [ADDR_W-1:0] wrap_base;

  always_comb begin
    beat_bytes = ADDR_W'(1) << size;
    aligned    = addr & ~(beat_bytes - ADDR_W'(1));
    incr       = aligned + beat_bytes;
    // Window is (len+1) beats, aligned to its own (power-of-two) size.
    wrap_size  = ADDR_W'({1'b0, len} + 9'd1) << size;
    wrap_base  = addr & ~(wrap_size - ADDR_W'(1));
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_WRAP:  next_addr = (incr == (wrap_base + wrap_size)) ? wrap_base : incr;
      default:     next_addr = incr;
    endcase
  end

endmodule

// File: rtl/axi_burst_read_slave.sv
// AXI4 read-channel slave serving FIXED/INCR/WRAP bursts from an internal
// word memory, with burst- and beat-level SLVERR and a backdoor write port.
module axi_burst_read_slave
  import axi_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int ID_W   = 4,
  parameter int DEPTH  = 256
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic [ID_W-1:0]          arid,
  input  logic [ADDR_W-1:0]        araddr,
  input  logic [7:0]               arlen,
  input  logic [2:0]               arsize,
  input  logic [1:0]               arburst,
  input  logic                     arvalid,
  output logic                     arready,
  output logic [ID_W-1:0]          rid,
  output logic [DATA_W-1:0]        rdata,
  output logic [1:0]               rresp,
  output logic                     rlast,
  output logic                     rvalid,
  input  logic                     rready,
  input  logic                     mem_we,
  input  logic [$clog2(DEPTH)-1:0] mem_waddr,
  input  logic [DATA_W-1:0]        mem_wdata
);

  localparam int MEM_AW     = $clog2(DEPTH);
  localparam int BYTE_SHIFT = $clog2(DATA_W / 8);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_q, addr_nxt, beat_addr, word_idx;
  logic [7:0]        len_q, cnt_q;
  logic [2:0]        size_q;
  logic [1:0]        burst_q;
  logic              berr_q, ar_err, beat_err;
  logic              ar_hs, r_hs, beat_load;
  logic [DATA_W-1:0] beat_data;
  logic [1:0]        beat_resp;
  logic [DATA_W-1:0] mem [DEPTH];

  axi_burst_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .addr      (addr_q),
    .len       (len_q),
    .size      (size_q),
    .burst     (burst_q),
    .next_addr (addr_nxt)
  );

  // State register and control/output registers
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state   <= ST_IDLE;
      arready <= 1'b0;
      cnt_q   <= '0;
      berr_q  <= 1'b0;
      rid     <= '0;
      rdata   <= '0;
      rresp   <= RESP_OKAY;
    end else begin
      state   <= state_nxt;
      arready <= (state_nxt == ST_IDLE);
      if (ar_hs) begin
        rid    <= arid;
        cnt_q  <= arlen;
        berr_q <= ar_err;
      end else if (beat_load) begin
        cnt_q  <= cnt_q - 8'd1;
      end
      if (beat_load) begin
        rdata <= beat_data;
        rresp <= beat_resp;
      end
    end
  end

  // Captured request fields only matter inside a burst, so they carry no reset.
  always_ff @(posedge aclk) begin
    if (ar_hs) begin
      len_q   <= arlen;
      size_q  <= arsize;
      burst_q <= arburst;
    end
    if (beat_load) addr_q <= beat_addr;
  end

  always_ff @(posedge aclk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (arvalid && arready) state_nxt = ST_BURST;
      ST_BURST: if (rready && (cnt_q == 8'd0)) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs and beat-load strobes
  always_comb begin
    rvalid    = (state == ST_BURST);
    rlast     = rvalid && (cnt_q == 8'd0);
    ar_hs     = arvalid && arready;
    r_hs      = rvalid && rready;
    beat_load = ar_hs || (r_hs && (cnt_q != 8'd0));
  end

  // Beat fetch: beat 0 comes straight from AR, later beats from the generator.
  always_comb begin
    ar_err = (arburst == BURST_RSVD) ||
             (int'(arsize) > BYTE_SHIFT) ||
             ((arburst == BURST_WRAP) && !wrap_len_ok(arlen));
    beat_addr = (state == ST_IDLE) ? araddr : addr_nxt;
    beat_err  = (state == ST_IDLE) ? ar_err : berr_q;
    word_idx  = beat_addr >> BYTE_SHIFT;
    beat_data = '0;
    beat_resp = RESP_SLVERR;
    if (!beat_err && (word_idx < ADDR_W'(DEPTH))) begin
      beat_data = mem[word_idx[MEM_AW-1:0]];
      beat_resp = RESP_OKAY;
    end
  end

endmodule

// File: tb/tb_axi_burst_read_slave.sv
// Directed and randomized bench for axi_burst_read_slave against a
// beat-list reference model computed from the burst address rules.
module tb_axi_burst_read_slave;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int ID_W   = 4;
  localparam int DEPTH  = 256;

  logic              aclk = 1'b0;
  logic              areset;
  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arvalid;
  logic              arready;
  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;
  logic              mem_we;
  logic [7:0]        mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  int errors = 0;
  int checks = 0;

  logic [31:0] model_mem [DEPTH];
  logic [31:0] exp_data [$];
  logic [1:0]  exp_resp [$];

  axi_burst_read_slave #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W), .DEPTH(DEPTH)
  ) dut (
    .aclk      (aclk),
    .areset    (areset),
    .arid      (arid),
    .araddr    (araddr),
    .arlen     (arlen),
    .arsize    (arsize),
    .arburst   (arburst),
    .arvalid   (arvalid),
    .arready   (arready),
    .rid       (rid),
    .rdata     (rdata),
    .rresp     (rresp),
    .rlast     (rlast),
    .rvalid    (rvalid),
    .rready    (rready),
    .mem_we    (mem_we),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata)
  );

  always #5 aclk = ~aclk;

  initial begin
    #5000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected beat list from the address rules, evaluated beat by beat.
  function automatic void build_model(input logic [31:0] start, input int len,
                                      input int size, input logic [1:0] burst);
    longint b, wsz, base, al, a, idx;
    bit berr;
    exp_data.delete();
    exp_resp.delete();
    b    = 64'd1 << size;
    berr = (burst == 2'b11) || (size > 2) ||
           (burst == 2'b10 && !(len == 1 || len == 3 || len == 7 || len == 15));
    al   = longint'(start) - (longint'(start) % b);
    wsz  = longint'(len + 1) * b;
    base = longint'(start) - (longint'(start) % wsz);
    for (int i = 0; i <= len; i++) begin
      if (i == 0 || burst == 2'b00) a = longint'(start);
      else if (burst == 2'b10)      a = base + ((al - base + i * b) % wsz);
      else                          a = al + i * b;
      idx = a / 4;
      if (berr || idx >= DEPTH) begin
        exp_data.push_back(32'h0);
        exp_resp.push_back(2'b10);
      end else begin
        exp_data.push_back(model_mem[int'(idx)]);
        exp_resp.push_back(2'b00);
      end
    end
  endfunction

  task automatic run_burst(input logic [3:0] id, input logic [31:0] addr, input int len,
                           input int size, input logic [1:0] burst,
                           input bit rnd_ready, input bit collide);
    int n, guard;
    bit held;
    logic [31:0] hd;
    logic [1:0]  hr;
    logic        hl;
    logic [31:0] newval;
    build_model(addr, len, size, burst);
    guard = 0;
    while (arready !== 1'b1 && guard < 20) begin
      @(posedge aclk); #1;
      guard++;
    end
    chk("arready_before_ar", arready, 1);
    arid    = id;
    araddr  = addr;
    arlen   = 8'(len);
    arsize  = 3'(size);
    arburst = burst;
    arvalid = 1'b1;
    newval  = ~model_mem[addr[9:2]];
    if (collide) begin
      mem_we    = 1'b1;
      mem_waddr = addr[9:2];
      mem_wdata = newval;
    end
    @(posedge aclk); #1;
    arvalid = 1'b0;
    mem_we  = 1'b0;
    if (collide) model_mem[addr[9:2]] = newval;
    chk("first_beat_rvalid", rvalid, 1);
    n = 0; guard = 0; held = 0;
    hd = '0; hr = '0; hl = 1'b0;
    while (n <= len && guard < 2000) begin
      chk("arready_in_burst", arready, 0);
      if (held) begin
        chk("hold_rvalid", rvalid, 1);
        chk("hold_rdata", rdata, hd);
        chk("hold_rresp", rresp, hr);
        chk("hold_rlast", rlast, hl);
        chk("hold_rid", rid, id);
      end
      rready = rnd_ready ? 1'($urandom % 2) : 1'b1;
      if (rvalid && rready) begin
        chk("beat_rdata", rdata, exp_data[n]);
        chk("beat_rresp", rresp, exp_resp[n]);
        chk("beat_rlast", rlast, (n == len));
        chk("beat_rid", rid, id);
        n++;
        held = 0;
      end else begin
        held = rvalid;
        hd = rdata; hr = rresp; hl = rlast;
      end
      @(posedge aclk); #1;
      guard++;
    end
    if (n <= len) chk("burst_beat_count", n, len + 1);
    rready = 1'b0;
    chk("post_burst_rvalid", rvalid, 0);
    chk("post_burst_arready", arready, 1);
  endtask

  initial begin
    int rlen, rsize;
    logic [1:0] rburst;
    areset = 1'b1;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
    rready = 1'b0; mem_we = 1'b0; mem_waddr = '0; mem_wdata = '0;

    // Preload the memory while reset is held; contents are not reset.
    for (int i = 0; i < DEPTH; i++) begin
      mem_we    = 1'b1;
      mem_waddr = 8'(i);
      mem_wdata = 32'hA000_0000 + 32'(i);
      model_mem[i] = 32'hA000_0000 + 32'(i);
      @(posedge aclk); #1;
    end
    mem_we = 1'b0;

    chk("reset_arready", arready, 0);
    chk("reset_rvalid", rvalid, 0);
    chk("reset_rlast", rlast, 0);
    chk("reset_rresp", rresp, 0);
    chk("reset_rdata", rdata, 0);
    chk("reset_rid", rid, 0);

    areset = 1'b0;
    chk("arready_low_at_release", arready, 0);
    @(posedge aclk); #1;
    chk("arready_after_release", arready, 1);

    // Directed cases
    run_burst(4'h5, 32'h10, 3, 2, 2'b01, 0, 0);
    chk("incr_last_beat_const", exp_data[3], 32'hA000_0007);
    run_burst(4'h3, 32'h38, 3, 2, 2'b10, 0, 0);
    chk("wrap_third_beat_const", exp_data[2], 32'hA000_000C);
    run_burst(4'h9, 32'h20, 2, 2, 2'b00, 0, 0);
    run_burst(4'hA, 32'h100, 7, 2, 2'b01, 1, 0);
    run_burst(4'h1, 32'h3FC, 1, 2, 2'b01, 0, 0);
    chk("range_beat1_resp_const", exp_resp[1], 2'b10);
    run_burst(4'h2, 32'h0, 3, 2, 2'b11, 0, 0);
    run_burst(4'h4, 32'h20, 2, 2, 2'b10, 0, 0);
    run_burst(4'h6, 32'h0, 0, 3, 2'b01, 0, 0);
    run_burst(4'h7, 32'h80, 1, 2, 2'b01, 0, 1);

    // Reset in the middle of a 4-beat burst, after beat 1 is accepted.
    build_model(32'h40, 3, 2, 2'b01);
    arid = 4'hC; araddr = 32'h40; arlen = 8'd3; arsize = 3'd2; arburst = 2'b01;
    arvalid = 1'b1;
    @(posedge aclk); #1;
    arvalid = 1'b0;
    rready  = 1'b1;
    chk("rst_beat0", rdata, exp_data[0]);
    @(posedge aclk); #1;
    chk("rst_beat1", rdata, exp_data[1]);
    @(posedge aclk); #1;
    rready = 1'b0;
    chk("rst_pre_rvalid", rvalid, 1);
    areset = 1'b1;
    #1;
    chk("rst_mid_rvalid", rvalid, 0);
    chk("rst_mid_rlast", rlast, 0);
    chk("rst_mid_arready", arready, 0);
    @(posedge aclk); #1;
    @(posedge aclk); #1;
    areset = 1'b0;
    @(posedge aclk); #1;
    chk("rst_release_arready", arready, 1);
    chk("rst_release_rvalid", rvalid, 0);
    run_burst(4'hD, 32'h44, 3, 2, 2'b01, 0, 0);

    // Randomized bursts, including out-of-range and illegal requests.
    for (int t = 0; t < 40; t++) begin
      rburst = 2'($urandom_range(0, 3));
      rsize  = int'($urandom_range(0, 3));
      if ($urandom % 4 == 0) rlen = int'($urandom_range(0, 31));
      else begin
        case ($urandom % 5)
          0: rlen = 0;
          1: rlen = 1;
          2: rlen = 3;
          3: rlen = 7;
          default: rlen = 15;
        endcase
      end
      run_burst(4'($urandom), 32'($urandom_range(0, 32'h47F)), rlen, rsize, rburst,
                1'($urandom % 2), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi_burst_read_slave.md
# axi_burst_read_slave

AXI4 read-channel slave that serves full INCR, FIXED and WRAP bursts from an internal word-addressed memory. It is the parametrised successor to the team's single-beat read channel: configurable data, address and ID widths and memory depth, proper `rlast`/`rid` signalling, and SLVERR on illegal or out-of-range requests. It sits behind the interconnect as a memory-mapped read target. A backdoor write port preloads contents for simulation and boot ROM use.

## Interface
- `DATA_W`, 32: R data width, power of two, 8..1024.
- `ADDR_W`, 32: byte address width.
- `ID_W`, 4: AR/R ID width.
- `DEPTH`, 256: memory depth in `DATA_W` words.
- `aclk` in 1: clock, all logic rising-edge.
- `areset` in 1: asynchronous, active-high reset.
- `arid` in `ID_W`: request ID.
- `araddr` in `ADDR_W`: start byte address.
- `arlen` in 8: beats minus one.
- `arsize` in 3: log2 bytes per beat.
- `arburst` in 2: 00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
- `arvalid` in 1 / `arready` out 1: AR handshake.
- `rid` out `ID_W`: echoes captured `arid`.
- `rdata` out `DATA_W`: beat data, full bus word.
- `rresp` out 2: 00 OKAY, 10 SLVERR.
- `rlast` out 1: final beat.
- `rvalid` out 1 / `rready` in 1: R handshake.
- `mem_we` in 1, `mem_waddr` in `$clog2(DEPTH)`, `mem_wdata` in `DATA_W`: backdoor word write.

## Operation
- States: IDLE and BURST.
- IDLE: `arready`=1. On `arvalid && arready`, the block latches `arid`, `arlen`, `arsize`, `arburst` and the address, loads beat 0 into `rdata`/`rresp`, sets the beat counter to `arlen`, and moves to BURST.
- BURST: `arready`=0 and `rvalid`=1.
  - On `rvalid && rready` when the counter is not 0: compute the next address, load the next beat, and decrement the counter.
  - On the handshake when the counter is 0: go to IDLE.
- `rlast`=1 exactly when the counter is 0 in BURST.
- Address generation, with `B=1<<arsize`:
  - FIXED: the address never changes.
  - INCR: next = (addr aligned down to B) + B.
  - WRAP: the wrap window is `(arlen+1)*B` bytes, aligned to a multiple of its own size. Next = aligned addr + B; when that reaches the window top, it wraps to the window base.
- Word index = addr >> log2(DATA_W/8). Narrow beats return the whole word; the master selects byte lanes.
- INCR 4 KB boundary crossings are not checked.
- Burst-level SLVERR is flagged at AR acceptance and applies to every beat: `arburst`=11, `arsize` > log2(DATA_W/8), or WRAP with `arlen` not in {1,3,7,15}.
- Beat-level SLVERR applies when the word index ≥ `DEPTH`.
- On any SLVERR beat, `rdata` = 0. The beat count is still honoured and `rlast` still asserts on the last beat.
- Memory contents are not reset. `mem_we` writes at the clock edge.

## Timing
- Reset values: `arready`=0, `rvalid`=0, `rlast`=0, `rresp`=00, `rdata`=0, `rid`=0, state IDLE.
- `arready` is registered and rises on the first edge after `areset` deasserts.
- The AR handshake at edge N gives beat 0 valid after edge N: one cycle from AR to first R.
- With `rready` held high, one beat per cycle.
- After the last-beat handshake at edge M, `arready`=1 after M. The next AR can be accepted at edge M+1, so there is one bubble per burst.
- `rdata`, `rresp`, `rlast` and `rid` remain stable while `rvalid && !rready`.
- If a backdoor write and a beat load target the same word on the same edge, the beat gets the old data.
- `areset` during BURST immediately drops `rvalid`/`rlast` and abandons the burst, with no completion. Memory contents are kept.

## Structure
- `axi_pkg` holds the burst encodings (FIXED/INCR/WRAP), the resp encodings (OKAY/SLVERR), and the state enum.
- One sub-module, `axi_burst_addr_gen`: combinational next-address and wrap-window computation from addr/len/size/burst. It is shared with the future write slave.
- The top level holds the FSM, beat counter, R-channel output registers, and the memory array.

## Test plan
Common setup: `DATA_W`=32, `DEPTH`=256, and `mem[i]` = 0xA000_0000+i preloaded via the backdoor.
- INCR, `araddr`=0x10, `arlen`=3, `arsize`=2, `rready`=1 → rdata 0xA0000004..07 on consecutive cycles, `rlast` on the 4th beat, OKAY, `rid` = `arid`.
- WRAP, `araddr`=0x38, `arlen`=3, `arsize`=2 → words 14, 15, 12, 13.
- FIXED, `araddr`=0x20, `arlen`=2 → three beats of 0xA0000008.
- `rready` toggled pseudo-randomly during INCR `arlen`=7 → every beat is held stable until accepted, exactly 8 beats, `arready` stays 0 throughout.
- Error cases:
  - `araddr`=0x3FC, INCR `arlen`=1 → beat 0 OKAY 0xA00000FF, beat 1 SLVERR data 0.
  - `arburst`=11 → all beats SLVERR.
  - WRAP `arlen`=2 → SLVERR, `rlast` on the 3rd beat.
- `areset` pulsed mid-burst (after beat 1 of 4) → `rvalid` drops immediately. After release, `arready`=1 and a new INCR burst returns correct data.
